// File: rtl/gpio_pkg.sv
// Shared GPIO constants and the per-bit debounce state view.
// Also used by the CoreMips integration.
package gpio_pkg;

  localparam int GPIO_WIDTH       = 8;
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One GPIO bit: 2-flop synchronizer, persistence counter, stable level, and
// one-cycle edge pulses.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          upd_q, upd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  db_state_e     state;

  always_comb begin
    sync1_d  = pin_i;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    upd_d    = 1'b0;
    state    = (cnt_q == '0) ? DB_STABLE : DB_PENDING;

    // Disabled: counter and stable level freeze where they are.
    if (en) begin
      case (state)
        DB_STABLE: begin
          if (sync2_q != stable_q) cnt_d = CW'(1);
        end
        DB_PENDING: begin
          if (sync2_q == stable_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            upd_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      upd_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      upd_q    <= upd_d;
      cnt_q    <= cnt_d;
    end
  end

  // Pulses line up with the cycle the new level first shows on level_o.
  assign level_o = stable_q;
  assign rise_o  = en & upd_q & stable_q;
  assign fall_o  = en & upd_q & ~stable_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: WIDTH independent debounced bits plus a combined
// change flag.
module gpio_in_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .pin_i  (pins_i[gi]),
        .level_o(gpio_o[gi]),
        .rise_o (rise_o[gi]),
        .fall_o (fall_o[gi])
      );
    end
  endgenerate

  assign changed_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed scenarios plus a randomized run, checked every cycle against a
// run-length reference model of the debounce rules.
module tb_gpio_in_debounce;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] pins_i;
  logic [W-1:0] gpio_o, rise_o, fall_o;
  logic         changed_o;

  always #5 clk = ~clk;

  gpio_in_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pins_i   (pins_i),
    .gpio_o   (gpio_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .changed_o(changed_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pin history delayed two edges, and per-bit length of the
  // current run of enabled cycles whose synchronized level disagrees.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_pulse = '0;
  int           m_run [W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [W-1:0] er, ef;
    @(posedge clk);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pulse = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_pulse = '0;
      if (en) begin
        for (int i = 0; i < W; i++) begin
          if (m_s2[i] != m_stable[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DC) begin
              m_stable[i] = m_s2[i];
              m_run[i]    = 0;
              m_pulse[i]  = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = pins_i;
    end
    #1;
    er = en ? (m_pulse & m_stable)  : '0;
    ef = en ? (m_pulse & ~m_stable) : '0;
    chk("model_gpio", 32'(gpio_o), 32'(m_stable));
    chk("model_rise", 32'(rise_o), 32'(er));
    chk("model_fall", 32'(fall_o), 32'(ef));
    chk("model_changed", 32'(changed_o), 32'(|(er | ef)));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  int hold;

  initial begin
    for (int i = 0; i < W; i++) m_run[i] = 0;
    rst = 1'b1; en = 1'b1; pins_i = 8'hFF;

    // Reset with all pins high, then acceptance six edges after release.
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rst_gpio", 32'(gpio_o), 32'h0);
      chk("rst_changed", 32'(changed_o), 32'h0);
    end
    rst = 1'b0;
    run(5);
    chk("rel_gpio_early", 32'(gpio_o), 32'h0);
    cycle();
    chk("rel_gpio", 32'(gpio_o), 32'hFF);
    chk("rel_rise", 32'(rise_o), 32'hFF);
    cycle();
    chk("rel_rise_once", 32'(rise_o), 32'h0);

    // Clean edge 00 -> 03.
    pins_i = 8'h00; run(10);
    chk("clean_base", 32'(gpio_o), 32'h00);
    pins_i = 8'h03; run(5);
    chk("clean_early", 32'(gpio_o), 32'h00);
    cycle();
    chk("clean_gpio", 32'(gpio_o), 32'h03);
    chk("clean_rise", 32'(rise_o), 32'h03);
    chk("clean_changed", 32'(changed_o), 32'h1);
    cycle();
    chk("clean_changed_once", 32'(changed_o), 32'h0);

    // Three-cycle glitch on bit 0 is rejected; a long pulse is accepted.
    pins_i = 8'h00; run(10);
    pins_i = 8'h01; run(3);
    pins_i = 8'h00; run(8);
    chk("glitch_gpio", 32'(gpio_o), 32'h00);
    pins_i = 8'h01; run(8);
    chk("glitch_accept", 32'(gpio_o), 32'h01);

    // Freeze after two counts on bit 1, resume and accept two edges later.
    pins_i = 8'h03; run(4);
    en = 1'b0; run(10);
    chk("freeze_gpio", 32'(gpio_o), 32'h01);
    en = 1'b1; cycle();
    chk("resume_early", 32'(gpio_o), 32'h01);
    cycle();
    chk("resume_gpio", 32'(gpio_o), 32'h03);
    chk("resume_rise", 32'(rise_o), 32'h02);

    // Mixed edges 0F -> F0.
    pins_i = 8'h0F; run(10);
    chk("mixed_base", 32'(gpio_o), 32'h0F);
    pins_i = 8'hF0; run(6);
    chk("mixed_gpio", 32'(gpio_o), 32'hF0);
    chk("mixed_rise", 32'(rise_o), 32'hF0);
    chk("mixed_fall", 32'(fall_o), 32'h0F);
    chk("mixed_changed", 32'(changed_o), 32'h1);
    cycle();
    chk("mixed_changed_once", 32'(changed_o), 32'h0);

    // Reset at count 3 aborts the transition; full acceptance afterwards.
    pins_i = 8'h00; run(10);
    pins_i = 8'h01; run(5);
    rst = 1'b1; cycle();
    chk("abort_gpio", 32'(gpio_o), 32'h00);
    rst = 1'b0; run(5);
    chk("abort_early", 32'(gpio_o), 32'h00);
    chk("abort_no_pulse", 32'(changed_o), 32'h0);
    cycle();
    chk("abort_accept", 32'(gpio_o), 32'h01);
    chk("abort_rise", 32'(rise_o), 32'h01);

    // Randomized levels with short and long holds, enable drops, rare resets.
    hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        pins_i = 8'($urandom);
        hold   = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
